// File: rtl/weight_fetch_controller.sv
// Weight fetch controller: issues credit-limited consecutive reads to one weight_buffer
// port and streams the returned rows to the weight loader through a small FWFT FIFO.
module weight_fetch_controller #(
  parameter int MATRIX_WIDTH = 4,
  parameter int ADDR_WIDTH   = 40,
  parameter int READ_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [$clog2(MATRIX_WIDTH+1)-1:0] row_count,
  output logic                              busy,
  output logic                              done,
  output logic                              buf_en,
  output logic                              buf_write_en,
  output logic [ADDR_WIDTH-1:0]             buf_addr,
  input  logic [MATRIX_WIDTH*8-1:0]         buf_read_data,
  output logic [MATRIX_WIDTH*8-1:0]         row_data,
  output logic [$clog2(MATRIX_WIDTH)-1:0]   row_index,
  output logic                              row_last,
  output logic                              row_valid,
  input  logic                              row_ready
);

  localparam int CW    = $clog2(MATRIX_WIDTH + 1);
  localparam int IW    = $clog2(MATRIX_WIDTH);
  localparam int DW    = MATRIX_WIDTH * 8;
  localparam int DEPTH = READ_LATENCY + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX_ROWS = CW'(MATRIX_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]           ret_idx_q, ret_idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NW-1:0]           outst_q, outst_d;
  logic [READ_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [NW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;

  logic [DW-1:0]           data_mem_q [DEPTH];
  logic [IW-1:0]           idx_mem_q  [DEPTH];
  logic                    last_mem_q [DEPTH];

  logic                    fifo_wr, fifo_pop, issue, credit, wr_last;
  logic [NW-1:0]           cnt_after_pop;
  logic [CW-1:0]           clamped_count;

  assign row_valid     = (fifo_cnt_q != '0);
  assign fifo_pop      = enable & row_valid & row_ready;
  assign fifo_wr       = enable & vpipe_q[READ_LATENCY-1];
  assign cnt_after_pop = fifo_cnt_q - NW'(fifo_pop);
  // A credit guarantees FIFO room for every read still travelling through the buffer.
  assign credit        = ({1'b0, outst_q} + {1'b0, cnt_after_pop}) < (NW+1)'(DEPTH);
  assign issue         = enable & (state_q == S_ISSUE) & credit;
  assign wr_last       = (ret_idx_q == (count_q - CW'(1)));
  assign clamped_count = (row_count > MAX_ROWS) ? MAX_ROWS : row_count;

  assign buf_en       = issue;
  assign buf_write_en = 1'b0;
  assign buf_addr     = addr_q;
  assign busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign row_data     = row_valid ? data_mem_q[rd_ptr_q] : '0;
  assign row_index    = row_valid ? idx_mem_q[rd_ptr_q]  : '0;
  assign row_last     = row_valid & last_mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    issue_cnt_d = issue_cnt_q;
    ret_idx_d   = ret_idx_q;
    addr_d      = addr_q;
    if (fifo_wr) ret_idx_d = ret_idx_q + CW'(1);
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_d      = base_addr;
            count_d     = clamped_count;
            issue_cnt_d = '0;
            ret_idx_d   = '0;
            state_d     = (clamped_count == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr_d      = addr_q + ADDR_WIDTH'(1);
            issue_cnt_d = issue_cnt_q + CW'(1);
            if (issue_cnt_q == (count_q - CW'(1))) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_pop && row_last) state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    vpipe_d = vpipe_q;
    if (enable) begin
      vpipe_d[0] = issue;
      for (int k = 1; k < READ_LATENCY; k++) vpipe_d[k] = vpipe_q[k-1];
    end
    outst_d = outst_q;
    if (issue && !fifo_wr)      outst_d = outst_q + NW'(1);
    else if (!issue && fifo_wr) outst_d = outst_q - NW'(1);
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_wr && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + NW'(1);
    else if (!fifo_wr && fifo_pop) fifo_cnt_d = fifo_cnt_q - NW'(1);
    wr_ptr_d = wr_ptr_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (fifo_pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      issue_cnt_q <= '0;
      ret_idx_q   <= '0;
      addr_q      <= '0;
      outst_q     <= '0;
      vpipe_q     <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issue_cnt_q <= issue_cnt_d;
      ret_idx_q   <= ret_idx_d;
      addr_q      <= addr_d;
      outst_q     <= outst_d;
      vpipe_q     <= vpipe_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the read side is masked by row_valid.
  always_ff @(posedge clk) begin
    if (!rst && fifo_wr) begin
      data_mem_q[wr_ptr_q] <= buf_read_data;
      idx_mem_q[wr_ptr_q]  <= ret_idx_q[IW-1:0];
      last_mem_q[wr_ptr_q] <= wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fifo_wr && !fifo_pop) assert (fifo_cnt_q < NW'(DEPTH));
  end

endmodule

// File: tb/tb_weight_fetch_controller.sv
// Self-checking bench for weight_fetch_controller: weight_buffer model with fixed read
// latency, row scoreboard, and per-cycle timing history relative to the start edge.
module tb_weight_fetch_controller;
  localparam int MW = 4;
  localparam int AW = 40;
  localparam int RL = 2;
  localparam int HN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [2:0]      row_count = '0;
  logic            busy, done, buf_en, buf_write_en;
  logic [AW-1:0]   buf_addr;
  logic [MW*8-1:0] buf_read_data;
  logic [MW*8-1:0] row_data;
  logic [1:0]      row_index;
  logic            row_last, row_valid;
  logic            row_ready = 1'b1;

  weight_fetch_controller #(.MATRIX_WIDTH(MW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .base_addr(base_addr),
    .row_count(row_count), .busy(busy), .done(done), .buf_en(buf_en),
    .buf_write_en(buf_write_en), .buf_addr(buf_addr), .buf_read_data(buf_read_data),
    .row_data(row_data), .row_index(row_index), .row_last(row_last),
    .row_valid(row_valid), .row_ready(row_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MW*8-1:0] data;
    logic [1:0]      idx;
    logic            last;
  } exp_t;

  exp_t        sb[$];
  logic [AW-1:0] iss_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 1000000;
  int hs_cnt = 0;
  int last_hs = -1;
  logic en_h[HN], v_h[HN], d_h[HN], b_h[HN];
  logic [AW-1:0] a_h[HN];

  function automatic logic [MW*8-1:0] data_of(input logic [AW-1:0] a);
    logic [MW*8-1:0] r;
    for (int j = 0; j < MW; j++) r[j*8 +: 8] = a[7:0] * 8'(j);
    return r;
  endfunction

  // weight_buffer model: fixed latency pipeline that advances only on enabled cycles
  logic [MW*8-1:0] bpipe [RL];
  always @(posedge clk) begin
    if (enable) begin
      bpipe[0] <= buf_en ? data_of(buf_addr) : '1;
      for (int k = 1; k < RL; k++) bpipe[k] <= bpipe[k-1];
    end
  end
  assign buf_read_data = bpipe[RL-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int rel;
    exp_t e;
    rel = cyc - t0 + 1;
    if (rel >= 0 && rel < HN) begin
      en_h[rel] = buf_en; v_h[rel] = row_valid; d_h[rel] = done; b_h[rel] = busy;
      a_h[rel] = buf_addr;
    end
    if (buf_en) iss_q.push_back(buf_addr);
    if (!rst && enable && row_valid && row_ready) begin
      hs_cnt++;
      last_hs = rel;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow unexpected row idx=%0d data=%h", row_index, row_data);
      end else begin
        e = sb.pop_front();
        if ({row_data, row_index, row_last} !== e) begin
          errors++;
          $display("FAIL sb_row got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                   row_data, row_index, row_last, e.data, e.idx, e.last);
        end
      end
    end
  end

  task automatic issue_cmd(input logic [AW-1:0] base, input int cnt);
    int n;
    exp_t e;
    t0 = 1000000;
    for (int i = 0; i < HN; i++) begin
      en_h[i] = 0; v_h[i] = 0; d_h[i] = 0; b_h[i] = 0; a_h[i] = '0;
    end
    iss_q.delete();
    hs_cnt = 0;
    last_hs = -1;
    n = (cnt > MW) ? MW : cnt;
    for (int i = 0; i < n; i++) begin
      e.data = data_of(base + AW'(i));
      e.idx  = 2'(i);
      e.last = (i == n - 1);
      sb.push_back(e);
    end
    base_addr = base;
    row_count = 3'(cnt);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, buf_en, buf_write_en, buf_addr, row_data, row_index, row_last, row_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b en=%b we=%b addr=%h valid=%b exp all 0",
               busy, done, buf_en, buf_write_en, buf_addr, row_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic;
    bit seen;
    int n = 4;
    row_ready = 1'b1;
    issue_cmd(40'h10, n);
    wait_done(40, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_done_timeout got none exp done"); end
    repeat (3) @(negedge clk);
    for (int r = 0; r < 15; r++) begin
      logic [3:0] exp, got;
      exp = {r >= 1 && r <= n, r >= RL + 2 && r <= RL + n + 1, r == RL + n + 2, r >= 1 && r <= RL + n + 1};
      got = {en_h[r], v_h[r], d_h[r], b_h[r]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_timing rel=%0d got en/v/d/b=%b exp=%b", r, got, exp);
      end
    end
    for (int r = 1; r <= n; r++) begin
      checks++;
      if (a_h[r] !== 40'h10 + AW'(r - 1)) begin
        errors++;
        $display("FAIL basic_addr rel=%0d got=%h exp=%h", r, a_h[r], 40'h10 + AW'(r - 1));
      end
    end
    checks++;
    if (hs_cnt !== n || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_rows got hs=%0d left=%0d exp hs=%0d left=0", hs_cnt, sb.size(), n);
    end
  endtask

  task automatic test_backpressure;
    bit seen;
    int early, total, done_rel;
    row_ready = 1'b0;
    issue_cmd(40'h40, 4);
    repeat (10) @(posedge clk);
    #1 row_ready = 1'b1;
    wait_done(40, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_done_timeout got none exp done"); end
    repeat (2) @(negedge clk);
    early = 0; total = 0; done_rel = -1;
    for (int r = 1; r < HN; r++) begin
      if (en_h[r]) total++;
      if (en_h[r] && r <= 10) early++;
      if (d_h[r] && done_rel < 0) done_rel = r;
    end
    checks++;
    if (early !== 3) begin errors++; $display("FAIL bp_stall_issues got=%0d exp=3", early); end
    checks++;
    if (total !== 4) begin errors++; $display("FAIL bp_total_issues got=%0d exp=4", total); end
    checks++;
    if (hs_cnt !== 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_rows got hs=%0d left=%0d exp hs=4 left=0", hs_cnt, sb.size());
    end
    checks++;
    if (done_rel !== last_hs + 1) begin
      errors++;
      $display("FAIL bp_done_after_last got=%0d exp=%0d", done_rel, last_hs + 1);
    end
  endtask

  task automatic test_enable_stall;
    bit seen;
    int done_rel;
    row_ready = 1'b1;
    issue_cmd(40'h80, 4);
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    wait_done(40, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_done_timeout got none exp done"); end
    repeat (2) @(negedge clk);
    for (int r = 3; r <= 5; r++) begin
      checks++;
      if ({en_h[r], v_h[r], d_h[r], b_h[r]} !== 4'b0001 || a_h[r] !== 40'h82) begin
        errors++;
        $display("FAIL stall_hold rel=%0d got en/v/d/b=%b addr=%h exp 0001 addr=82",
                 r, {en_h[r], v_h[r], d_h[r], b_h[r]}, a_h[r]);
      end
    end
    checks++;
    if (iss_q.size() != 4) begin
      errors++;
      $display("FAIL stall_issue_count got=%0d exp=4", iss_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (iss_q[i] !== 40'h80 + AW'(i)) begin
          errors++;
          $display("FAIL stall_addr i=%0d got=%h exp=%h", i, iss_q[i], 40'h80 + AW'(i));
        end
      end
    end
    done_rel = -1;
    for (int r = 1; r < HN; r++) if (d_h[r] && done_rel < 0) done_rel = r;
    checks++;
    if (done_rel !== RL + 4 + 2 + 3) begin
      errors++;
      $display("FAIL stall_done_cycle got=%0d exp=%0d", done_rel, RL + 4 + 2 + 3);
    end
  endtask

  task automatic test_edge_counts;
    bit seen;
    int done_rel, busy_cnt;
    issue_cmd(40'h05, 0);
    wait_done(10, seen);
    repeat (4) @(negedge clk);
    done_rel = -1; busy_cnt = 0;
    for (int r = 0; r < 8; r++) begin
      if (d_h[r] && done_rel < 0) done_rel = r;
      if (en_h[r] || b_h[r]) busy_cnt++;
    end
    checks++;
    if (!seen || done_rel !== 1 || busy_cnt !== 0 || iss_q.size() != 0) begin
      errors++;
      $display("FAIL zero_count got done_rel=%0d en_or_busy=%0d issues=%0d exp 1 0 0",
               done_rel, busy_cnt, iss_q.size());
    end
    issue_cmd(40'h30, 7);
    start = 1'b1;
    wait_done(40, seen);
    start = 1'b0;
    repeat (6) @(negedge clk);
    done_rel = -1;
    for (int r = 1; r < HN; r++) if (d_h[r] && done_rel < 0) done_rel = r;
    checks++;
    if (!seen || done_rel !== RL + 4 + 2) begin
      errors++;
      $display("FAIL clamp_done got=%0d exp=%0d", done_rel, RL + 4 + 2);
    end
    checks++;
    if (iss_q.size() != 4 || hs_cnt !== 4 || sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_rows got issues=%0d hs=%0d left=%0d busy=%b exp 4 4 0 0",
               iss_q.size(), hs_cnt, sb.size(), busy);
    end
  endtask

  task automatic test_reset_drain;
    bit seen;
    int vcnt, done_rel;
    row_ready = 1'b1;
    issue_cmd(40'h60, 2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({busy, done, buf_en, buf_write_en, buf_addr, row_data, row_index, row_last, row_valid} !== '0) begin
      errors++;
      $display("FAIL rst_drain_outputs got busy=%b done=%b en=%b addr=%h valid=%b exp all 0",
               busy, done, buf_en, buf_addr, row_valid);
    end
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (row_valid) vcnt++;
    end
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL rst_late_data got valid_cycles=%0d exp=0", vcnt); end
    issue_cmd(40'h20, 2);
    wait_done(30, seen);
    repeat (2) @(negedge clk);
    done_rel = -1;
    for (int r = 1; r < HN; r++) if (d_h[r] && done_rel < 0) done_rel = r;
    checks++;
    if (!seen || done_rel !== RL + 2 + 2 || hs_cnt !== 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL rst_next_cmd got done_rel=%0d hs=%0d left=%0d exp %0d 2 0",
               done_rel, hs_cnt, sb.size(), RL + 4);
    end
  endtask

  task automatic test_addr_wrap;
    bit seen;
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 40'hFF_FFFF_FFFE;
    exp_a[1] = 40'hFF_FFFF_FFFF;
    exp_a[2] = 40'h00_0000_0000;
    row_ready = 1'b1;
    issue_cmd(40'hFF_FFFF_FFFE, 3);
    wait_done(30, seen);
    repeat (2) @(negedge clk);
    checks++;
    if (!seen || iss_q.size() != 3 || hs_cnt !== 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_cmd got seen=%b issues=%0d hs=%0d left=%0d exp 1 3 3 0",
               seen, iss_q.size(), hs_cnt, sb.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (iss_q[i] !== exp_a[i]) begin
          errors++;
          $display("FAIL wrap_addr i=%0d got=%h exp=%h", i, iss_q[i], exp_a[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_stall();
    test_edge_counts();
    test_reset_drain();
    test_addr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/weight_fetch_controller.md
Name: weight_fetch_controller

Overview:
Sequences tile reads from one port of weight_buffer and delivers each weight row to the systolic-array weight loader over a valid/ready stream.
- Accepts a start command carrying a base address and a row count, then issues consecutive buffer reads.
- Tracks the fixed buffer read latency and absorbs back-pressure in an internal credit-controlled FIFO.
- Signals completion with a one-cycle done pulse.

Parameters:
MATRIX_WIDTH, 4, bytes per weight row and maximum rows per tile.
ADDR_WIDTH, 40, weight address width; equals the width of weight_addr_type.
READ_LATENCY, 2, cycles from buf_en/buf_addr sampled to buf_read_data valid; must match the weight_buffer build (1..8).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  global advance; when 0 the block and the buffer hold state
start  in  1  command strobe, accepted only in IDLE
base_addr  in  ADDR_WIDTH  first weight row address
row_count  in  $clog2(MATRIX_WIDTH+1)  rows to fetch; 0 is legal
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
buf_en  out  1  buffer port enable
buf_write_en  out  1  buffer write enable, held 0
buf_addr  out  ADDR_WIDTH  buffer read address
buf_read_data  in  MATRIX_WIDTH*8  buffer read port (byte_type array)
row_data  out  MATRIX_WIDTH*8  FIFO head row
row_index  out  $clog2(MATRIX_WIDTH)  index of the head row within the tile
row_last  out  1  head row is the final row
row_valid  out  1  head row present
row_ready  in  1  consumer accepts the head row

Behaviour:
- Reset:
  - rst is sampled on the clk edge and overrides enable.
  - All outputs reset to 0. The state machine goes to IDLE, and the FIFO, outstanding counter and latency valid-pipe are cleared.
  - Data returning after reset from reads issued before reset is discarded, because the valid-pipe has been cleared.
- Enable:
  - When enable=0 nothing changes: state, counters, FIFO and pipe all hold, and buf_en=0.
  - Latency is counted in enabled cycles only.
- States:
  - IDLE: start=1 latches base_addr, and latches row_count clamped to MATRIX_WIDTH. If the clamped count is 0, go to DONE; otherwise go to ISSUE.
  - ISSUE: a read is issued in any cycle where a credit is available. On the last issue, go to DRAIN.
  - DRAIN: wait for every row to be handshaken out. On the handshake of the row with row_last=1, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. A start arriving in DONE is ignored.
- busy is 1 in ISSUE and DRAIN, and 0 in IDLE and DONE.
- Issue and credit:
  - FIFO_DEPTH = READ_LATENCY+1.
  - A read is issued (buf_en=1, buf_addr = base+i) only when outstanding + fifo_count_after_pop < FIFO_DEPTH. Here fifo_count_after_pop accounts for a pop happening in the same cycle.
  - i runs 0..count-1. Addresses are computed modulo 2^ADDR_WIDTH, so they wrap from all-ones to 0.
- Return path:
  - A READ_LATENCY-deep valid shift register mirrors the buffer pipeline.
  - When its output is 1, buf_read_data is written into the FIFO together with its index and a last flag.
  - The FIFO never overflows; any overflow is an assertion failure in simulation.
- Output:
  - The FIFO is first-word-fall-through. row_valid = FIFO not empty.
  - A pop occurs on row_valid & row_ready.
  - Rows are delivered strictly in order.
- Timing with row_ready held at 1 (start sampled at edge 0):
  - buf_en is high in cycles 1..count.
  - row_valid is high in cycles READ_LATENCY+2 .. READ_LATENCY+count+1.
  - done is high in cycle READ_LATENCY+count+2.
  - Throughput is one row per cycle.
- Simultaneous events: a FIFO write and pop in the same cycle leave the FIFO count unchanged.

Test Plan:
1. Basic fetch (MATRIX_WIDTH=4, READ_LATENCY=2), base=0x10, count=4, row_ready=1 -> buf_en in cycles 1-4 with addr 0x10..0x13. row_valid in cycles 4-7 with row_index 0..3 and row_last only on index 3. Data matches preloaded bytes i*j. done in cycle 8. busy in cycles 1-7.
2. Back-pressure: row_ready=0 for 10 cycles after start, count=4 -> exactly 3 reads issued, then buf_en stays 0. After row_ready=1, the fourth read issues, all 4 rows arrive in order with none lost, and done follows the last handshake by 1 cycle.
3. Enable stall: enable=0 for 3 cycles after the second issue -> buf_en=0 and all outputs hold. The address sequence resumes at base+2, and the total cycle count is the unstalled value + 3.
4. Edge counts: count=0 -> done one cycle after start and buf_en never asserted. count=7 -> clamped to 4 rows. A start held during busy is ignored, with no second command.
5. Reset mid-DRAIN: rst for 1 cycle with 2 reads in flight -> the next cycle has all outputs 0, late buffer data produces no row_valid, and a following command (base=0x20, count=2) completes normally.
6. Address wrap: base=2^40-2, count=3 -> buf_addr sequence 0xFFFFFFFFFE, 0xFFFFFFFFFF, 0x0000000000, and row_index 0..2.
